// File: rtl/button_event_pkg.sv
// Shared definitions for the button event arbiter: FSM encoding and a width helper.
package button_event_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    // Constant function so the index width can be derived at elaboration time.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/button_event_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap-around.
module rr_pick #(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = 2
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [IDX_W-1:0]  gnt_idx,
    output logic              any
);

    int idx;

    // Scanning downward and letting the last hit win yields the first hit scanning upward.
    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_CH;
            if (req[idx]) begin
                gnt_idx = IDX_W'(idx);
                any     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/button_event_arbiter.sv
// Synchronises NUM_CH board inputs, latches rising edges as pending events and hands
// them one at a time to a single consumer in round-robin order.
module button_event_arbiter
    import button_event_pkg::*;
#(
    parameter  int NUM_CH      = 4,
    parameter  int SYNC_STAGES = 2,
    localparam int IDX_W       = (NUM_CH > 1) ? clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] sig_in,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [IDX_W-1:0]  evt_ch,
    output logic [NUM_CH-1:0] pending,
    output logic [NUM_CH-1:0] overflow,
    input  logic              overflow_clr
);

    state_t           state_q;
    state_t           state_d;
    logic             load;
    logic             xfer;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] gnt_idx;
    logic             any;
    logic [IDX_W-1:0] next_ptr;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   last_q;
        logic                   pend_q;
        logic                   ovf_q;
        logic                   edge_det;
        logic                   load_clr;

        assign edge_det = sync_q[SYNC_STAGES-1] & ~last_q;
        assign load_clr = load && (gnt_idx == IDX_W'(i));

        // A new edge wins over the load-clear, so an edge arriving as the old one is
        // taken is not lost; it only counts as overflow if the old one stays pending.
        always_ff @(posedge clk) begin
            if (reset) begin
                sync_q <= '0;
                last_q <= 1'b0;
                pend_q <= 1'b0;
                ovf_q  <= 1'b0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in[i]};
                last_q <= sync_q[SYNC_STAGES-1];
                pend_q <= edge_det | (pend_q & ~load_clr);
                ovf_q  <= (edge_det & pend_q & ~load_clr) | (ovf_q & ~overflow_clr);
            end
        end

        assign pending[i]  = pend_q;
        assign overflow[i] = ovf_q;
    end

    rr_pick #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_rr_pick (
        .req     (pending),
        .ptr     (rr_ptr),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    assign next_ptr = IDX_W'((int'(evt_ch) + 1) % NUM_CH);

    // Handshake: evt_valid and evt_ch are held stable from load until the cycle where
    // evt_valid & evt_ready are both high; that cycle is the single transfer.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        xfer    = 1'b0;
        case (state_q)
            IDLE: begin
                if (any) begin
                    load    = 1'b1;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (evt_ready) begin
                    xfer    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            evt_ch  <= '0;
            rr_ptr  <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                evt_ch <= gnt_idx;
            end
            if (xfer) begin
                rr_ptr <= next_ptr;
            end
        end
    end

    assign evt_valid = (state_q == PRESENT);

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed and random checks of button_event_arbiter against a cycle-level event model.
module tb_button_event_arbiter;

    localparam int NUM_CH      = 4;
    localparam int SYNC_STAGES = 2;
    localparam int IDX_W       = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NUM_CH-1:0] sig_in;
    logic              evt_valid;
    logic              evt_ready;
    logic [IDX_W-1:0]  evt_ch;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] overflow;
    logic              overflow_clr;

    button_event_arbiter #(
        .NUM_CH      (NUM_CH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sig_in       (sig_in),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_ch       (evt_ch),
        .pending      (pending),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    always #5 clk = ~clk;

    int tests    = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model state: input history, latched events, presented event.
    logic [NUM_CH-1:0] m_hist[$];
    logic [NUM_CH-1:0] m_last;
    logic [NUM_CH-1:0] m_pend;
    logic [NUM_CH-1:0] m_over;
    logic              m_valid;
    int                m_ch;
    int                m_ptr;

    int got_q[$];
    int got_t[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_hist = {};
        for (int s = 0; s < SYNC_STAGES; s++) m_hist.push_back('0);
        m_last  = '0;
        m_pend  = '0;
        m_over  = '0;
        m_valid = 1'b0;
        m_ch    = 0;
        m_ptr   = 0;
    endtask

    task automatic model_step();
        logic [NUM_CH-1:0] rise;
        logic [NUM_CH-1:0] taken;
        logic [NUM_CH-1:0] lost;
        int                pick;
        if (reset) begin
            model_reset();
            return;
        end
        rise  = m_hist[0] & ~m_last;
        taken = '0;
        if (!m_valid) begin
            pick = -1;
            for (int k = 0; k < NUM_CH; k++) begin
                int c;
                c = (m_ptr + k) % NUM_CH;
                if (pick < 0 && m_pend[c]) pick = c;
            end
            if (pick >= 0) begin
                taken[pick] = 1'b1;
                m_valid     = 1'b1;
                m_ch        = pick;
            end
        end else if (evt_ready) begin
            m_valid = 1'b0;
            m_ptr   = (m_ch + 1) % NUM_CH;
        end
        lost   = rise & m_pend & ~taken;
        m_pend = (m_pend & ~taken) | rise;
        m_over = (overflow_clr ? '0 : m_over) | lost;
        m_last = m_hist[0];
        void'(m_hist.pop_front());
        m_hist.push_back(sig_in);
    endtask

    task automatic tick();
        if (!reset && evt_valid === 1'b1 && evt_ready) begin
            got_q.push_back(int'(evt_ch));
            got_t.push_back(cyc);
        end
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        check("model_valid", 32'(evt_valid), 32'(m_valid));
        check("model_ch", 32'(evt_ch), 32'(m_ch));
        check("model_pending", 32'(pending), 32'(m_pend));
        check("model_overflow", 32'(overflow), 32'(m_over));
    endtask

    task automatic clear_log();
        got_q = {};
        got_t = {};
    endtask

    initial begin
        int hold_ch;
        int n;
        int budget;
        reset        = 1'b1;
        sig_in       = '0;
        evt_ready    = 1'b1;
        overflow_clr = 1'b0;
        model_reset();

        // 1: single held input, exact latency, one event only
        repeat (3) tick();
        check("reset_valid", 32'(evt_valid), 32'd0);
        check("reset_pending", 32'(pending), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        reset  = 1'b0;
        sig_in = 4'b0100;
        clear_log();
        repeat (3) tick();
        check("t1_valid_before_edge4", 32'(evt_valid), 32'd0);
        tick();
        check("t1_valid_edge4", 32'(evt_valid), 32'd1);
        check("t1_ch_edge4", 32'(evt_ch), 32'd2);
        tick();
        check("t1_valid_after_xfer", 32'(evt_valid), 32'd0);
        repeat (10) tick();
        check("t1_event_count", 32'(got_q.size()), 32'd1);
        check("t1_pending", 32'(pending), 32'd0);

        // 2: round-robin order after ch1 grant
        sig_in = '0;
        repeat (6) tick();
        clear_log();
        sig_in = 4'b0010;
        budget = 0;
        while (got_q.size() == 0 && budget < 12) begin
            tick();
            budget++;
        end
        check("t2_first_ch1", 32'(got_q.size() > 0 ? got_q[0] : -1), 32'd1);
        sig_in = '0;
        repeat (4) tick();
        clear_log();
        sig_in = 4'b1001;
        repeat (12) tick();
        check("t2_count", 32'(got_q.size()), 32'd2);
        if (got_q.size() == 2) begin
            check("t2_order_first", 32'(got_q[0]), 32'd3);
            check("t2_order_second", 32'(got_q[1]), 32'd0);
            check("t2_spacing", 32'(got_t[1] - got_t[0]), 32'd2);
        end

        // 3: back-pressure holds the event stable
        sig_in = '0;
        repeat (6) tick();
        evt_ready = 1'b0;
        sig_in    = 4'b0100;
        budget    = 0;
        while (evt_valid !== 1'b1 && budget < 12) begin
            tick();
            budget++;
        end
        check("t3_presented", 32'(evt_valid), 32'd1);
        check("t3_ch", 32'(evt_ch), 32'd2);
        hold_ch = int'(evt_ch);
        for (int c = 0; c < 10; c++) begin
            tick();
            check("t3_hold_valid", 32'(evt_valid), 32'd1);
            check("t3_hold_ch", 32'(evt_ch), 32'(hold_ch));
        end
        clear_log();
        evt_ready = 1'b1;
        repeat (5) tick();
        check("t3_one_transfer", 32'(got_q.size()), 32'd1);

        // 4: overflow on a channel that is already pending
        sig_in    = '0;
        evt_ready = 1'b0;
        repeat (6) tick();
        clear_log();
        for (int p = 0; p < 3; p++) begin
            sig_in = 4'b0010;
            repeat (4) tick();
            sig_in = 4'b0000;
            repeat (4) tick();
        end
        check("t4_overflow1", 32'(overflow[1]), 32'd1);
        check("t4_pending1", 32'(pending[1]), 32'd1);
        evt_ready = 1'b1;
        repeat (12) tick();
        n = 0;
        foreach (got_q[j]) if (got_q[j] == 1) n++;
        check("t4_ch1_events", 32'(n), 32'd2);
        check("t4_total_events", 32'(got_q.size()), 32'd2);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        check("t4_overflow_cleared", 32'(overflow), 32'd0);

        // 5: reset while presenting with other channels pending
        evt_ready = 1'b0;
        repeat (4) tick();
        sig_in = 4'b0001;
        repeat (6) tick();
        sig_in = 4'b1011;
        repeat (5) tick();
        check("t5_pending", 32'(pending), 32'b1010);
        check("t5_valid", 32'(evt_valid), 32'd1);
        sig_in = '0;
        reset  = 1'b1;
        repeat (2) tick();
        reset     = 1'b0;
        evt_ready = 1'b1;
        clear_log();
        tick();
        check("t5_valid_after_reset", 32'(evt_valid), 32'd0);
        check("t5_pending_after_reset", 32'(pending), 32'd0);
        repeat (20) tick();
        check("t5_no_events", 32'(got_q.size()), 32'd0);

        // 6: input already high at reset release
        sig_in = 4'b0001;
        reset  = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        clear_log();
        repeat (25) tick();
        check("t6_event_count", 32'(got_q.size()), 32'd1);
        check("t6_event_ch", 32'(got_q.size() > 0 ? got_q[0] : -1), 32'd0);

        // Random phase: toggling inputs, ready, clears and occasional reset
        for (int r = 0; r < 800; r++) begin
            logic [NUM_CH-1:0] flip;
            for (int b = 0; b < NUM_CH; b++) flip[b] = ($urandom_range(0, 5) == 0);
            sig_in       = sig_in ^ flip;
            evt_ready    = ($urandom_range(0, 3) != 0);
            overflow_clr = ($urandom_range(0, 15) == 0);
            reset        = ($urandom_range(0, 199) == 0);
            tick();
        end
        reset        = 1'b0;
        overflow_clr = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
